// File: rtl/deadlock_monitor_pkg.sv
// deadlock_monitor_pkg
// Shared definitions for the dataflow deadlock monitors:
//   - default child-process count and default hold time
//   - width helper for the consecutive-cycle counter
//   - WATCH / DEADLOCKED state encoding
package deadlock_monitor_pkg;

  localparam int DEF_NUM_AXIS    = 2;
  localparam int DEF_HOLD_CYCLES = 1000;

  typedef enum logic {
    WATCH      = 1'b0,
    DEADLOCKED = 1'b1
  } mon_state_t;

  // floor(log2(hold)) + 1 : wide enough to hold HOLD_CYCLES-1 for any legal hold.
  function automatic int cnt_width(input int hold);
    int w;
    w = 1;
    for (int v = hold; v > 1; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/deadlock_hold_counter.sv
// deadlock_hold_counter
// Counts consecutive cycles with en=1 and flags the cycle in which the
// HOLD_CYCLES-th consecutive true sample is presented. The count saturates at
// the terminal value and never wraps; freeze holds it unchanged.
// Ports:
//   clock  in  rising-edge clock
//   reset  in  asynchronous active-high reset (count -> 0)
//   en     in  condition being timed
//   freeze in  hold the count and suppress done
//   done   out high while the current sample completes the hold time
module deadlock_hold_counter
  import deadlock_monitor_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic freeze,
  output logic done
);

  localparam int CW = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The count already holds HOLD_CYCLES-1 prior true samples, so the current
  // true sample is the one that completes the hold time.
  assign done = en & ~freeze & (cnt == TERM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (!en) begin
        cnt <= '0;
      end else if (cnt != TERM) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// deadlock_idx0_monitor
// Deadlock detector for one kernel dataflow region. Raises a sticky block flag
// once every process has been idle or blocked (with at least one blocked) for
// HOLD_CYCLES consecutive cycles.
// Ports:
//   clock            in  rising-edge clock
//   reset            in  asynchronous active-high reset
//   axis_block_sigs  in  [NUM_AXIS] bit k-1: child k stalled on its stream
//   inst_idle_sigs   in  [NUM_INST] bit i: process i idle (index 0 = top)
//   inst_block_sigs  in  [1] top-level process blocked on a sub-instance
//   block            out sticky deadlock indication
// Optional feature: define DEADLOCK_MONITOR_REPORT_EN to capture the input
// vectors at detection and print one simulation message per detection.
module deadlock_idx0_monitor
  import deadlock_monitor_pkg::*;
#(
  parameter int NUM_AXIS    = DEF_NUM_AXIS,
  parameter int NUM_INST    = NUM_AXIS + 1,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [0:0]          inst_block_sigs,
  output logic                block
);

  mon_state_t state, state_next;
  logic any_blocked;
  logic all_quiet;
  logic cond;
  logic done;
  logic freeze;

  // All idle with nothing blocked is a clean finish, hence the any_blocked term.
  always_comb begin
    any_blocked = (|axis_block_sigs) | inst_block_sigs[0];
    all_quiet   = inst_idle_sigs[0] | inst_block_sigs[0] | any_blocked;
    for (int k = 1; k <= NUM_AXIS; k++) begin
      all_quiet = all_quiet & (inst_idle_sigs[k] | axis_block_sigs[k-1]);
    end
    cond = any_blocked & all_quiet;
  end

  assign freeze = (state == DEADLOCKED);

  deadlock_hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clock (clock),
    .reset (reset),
    .en    (cond),
    .freeze(freeze),
    .done  (done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= WATCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    block      = 1'b0;
    case (state)
      WATCH: begin
        if (done) begin
          state_next = DEADLOCKED;
        end
      end
      DEADLOCKED: begin
        block = 1'b1;
      end
      default: begin
        state_next = WATCH;
      end
    endcase
  end

`ifdef DEADLOCK_MONITOR_REPORT_EN
  logic [NUM_AXIS-1:0] dbg_axis_block;
  logic [NUM_INST-1:0] dbg_inst_idle;
  logic [0:0]          dbg_inst_block;

  // Only the single WATCH->DEADLOCKED edge captures, so one message per detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dbg_axis_block <= '0;
      dbg_inst_idle  <= '0;
      dbg_inst_block <= '0;
    end else if (state == WATCH && done) begin
      dbg_axis_block <= axis_block_sigs;
      dbg_inst_idle  <= inst_idle_sigs;
      dbg_inst_block <= inst_block_sigs;
      $display("%0t: deadlock detected axis_block_sigs=%b inst_idle_sigs=%b inst_block_sigs=%b",
               $time, axis_block_sigs, inst_idle_sigs, inst_block_sigs);
    end
  end
`endif

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Bench for deadlock_idx0_monitor with HOLD_CYCLES=4, NUM_AXIS=2:
// table-driven directed vectors, a hand-written asynchronous reset sequence,
// and randomized stimulus against a run-length reference model.
module tb_deadlock_idx0_monitor;

  localparam int NA   = 2;
  localparam int NI   = NA + 1;
  localparam int HOLD = 4;

  logic          clock;
  logic          reset;
  logic [NA-1:0] axis_block_sigs;
  logic [NI-1:0] inst_idle_sigs;
  logic [0:0]    inst_block_sigs;
  logic          block;

  int total;
  int bad;

  deadlock_idx0_monitor #(
    .NUM_AXIS   (NA),
    .NUM_INST   (NI),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs (inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .block          (block)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] axis;
    logic [2:0] idle;
    logic       iblk;
    logic       rst;
    int         reps;
    logic       exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: block=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a deadlock exists when something is blocked and the number of
  // quiet processes equals the number of processes.
  function automatic logic ref_cond(input logic [1:0] ax, input logic [2:0] id, input logic ib);
    int   quiet;
    logic blocked;
    blocked = (ax != 2'b00) || ib;
    quiet = 0;
    if (id[0] || ib || blocked) quiet++;
    for (int k = 1; k <= NA; k++) begin
      if (id[k] || ax[k-1]) quiet++;
    end
    return blocked && (quiet == NI);
  endfunction

  initial begin
    int   run;
    logic mblock;
    logic [1:0] ra;
    logic [2:0] ri;
    logic rb;
    int   hold_len;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    axis_block_sigs = '0;
    inst_idle_sigs  = '0;
    inst_block_sigs = '0;

    //               axis   idle    iblk rst  reps exp
    tbl.push_back('{2'b00, 3'b000, 1'b0, 1'b1, 2,  1'b0});
    tbl.push_back('{2'b00, 3'b000, 1'b0, 1'b0, 20, 1'b0});
    tbl.push_back('{2'b01, 3'b100, 1'b0, 1'b0, 3,  1'b0});
    tbl.push_back('{2'b01, 3'b100, 1'b0, 1'b0, 1,  1'b1});
    tbl.push_back('{2'b00, 3'b000, 1'b0, 1'b0, 3,  1'b1});
    tbl.push_back('{2'b00, 3'b000, 1'b0, 1'b1, 1,  1'b0});
    tbl.push_back('{2'b01, 3'b000, 1'b0, 1'b0, 10, 1'b0});
    tbl.push_back('{2'b11, 3'b000, 1'b0, 1'b0, 3,  1'b0});
    tbl.push_back('{2'b00, 3'b000, 1'b0, 1'b0, 1,  1'b0});
    tbl.push_back('{2'b11, 3'b000, 1'b0, 1'b0, 3,  1'b0});
    tbl.push_back('{2'b11, 3'b000, 1'b0, 1'b0, 1,  1'b1});
    tbl.push_back('{2'b00, 3'b000, 1'b0, 1'b1, 1,  1'b0});
    tbl.push_back('{2'b00, 3'b111, 1'b0, 1'b0, 50, 1'b0});
    tbl.push_back('{2'b00, 3'b000, 1'b1, 1'b0, 5,  1'b0});
    tbl.push_back('{2'b00, 3'b110, 1'b1, 1'b0, 3,  1'b0});
    tbl.push_back('{2'b00, 3'b110, 1'b1, 1'b0, 1,  1'b1});

    // Reset value while reset is asserted.
    #2;
    check("reset_value", block, 1'b0);
    @(negedge clock);

    // Directed table: inputs change on the falling edge, checked one edge later.
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        axis_block_sigs    = tbl[i].axis;
        inst_idle_sigs     = tbl[i].idle;
        inst_block_sigs[0] = tbl[i].iblk;
        reset              = tbl[i].rst;
        @(posedge clock);
        @(negedge clock);
        check($sformatf("tbl%0d.%0d", i, r), block, tbl[i].exp);
      end
    end

    // Asynchronous reset pulse mid-cycle after detection, cond held throughout.
    reset = 1'b0;
    axis_block_sigs = 2'b01;
    inst_idle_sigs  = 3'b100;
    inst_block_sigs = 1'b0;
    @(posedge clock); @(negedge clock);  // block already high from table end
    check("pre_reset_high", block, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_clear", block, 1'b0);
    @(posedge clock); @(negedge clock);
    check("held_in_reset", block, 1'b0);
    #2 reset = 1'b0;
    for (int e = 1; e <= HOLD; e++) begin
      @(posedge clock); @(negedge clock);
      check($sformatf("rearm_edge%0d", e), block, (e == HOLD) ? 1'b1 : 1'b0);
    end

    // Randomized stimulus against the run-length model.
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset  = 1'b0;
    run    = 0;
    mblock = 1'b0;
    for (int seg = 0; seg < 150; seg++) begin
      ra = 2'($urandom_range(0, 3));
      ri = 3'($urandom_range(0, 7));
      rb = ($urandom_range(0, 4) == 0);
      hold_len = $urandom_range(1, 6);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
      end
      for (int c = 0; c < hold_len; c++) begin
        axis_block_sigs    = ra;
        inst_idle_sigs     = ri;
        inst_block_sigs[0] = rb;
        @(posedge clock);
        if (reset) begin
          run    = 0;
          mblock = 1'b0;
        end else if (!mblock) begin
          if (ref_cond(ra, ri, rb)) begin
            run++;
            if (run == HOLD) mblock = 1'b1;
          end else begin
            run = 0;
          end
        end
        @(negedge clock);
        check($sformatf("rand%0d.%0d", seg, c), block, mblock);
        reset = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
